mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_muldiv.sv | 136 +++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide.
// Define MULDIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle 64-bit multiply.
module mips_cpu_muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;   // {remainder/product-high, quotient/product-low}
   logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic        div_q, div_d, neg_q, neg_d, sa_q, sa_d, done_q, done_d;

   logic        sgn, a_neg, b_neg, rem_ge;
   logic [31:0] a_mag, b_mag, quo, rem;
   logic [32:0] mul_sum, rem_sh, rem_sub;
   logic [63:0] prod;

   assign sgn   = (op == 3'd0) || (op == 3'd2);
   assign a_neg = sgn & a[31];
   assign b_neg = sgn & b[31];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_d   = div_q;
      neg_d   = neg_q;
      sa_d    = sa_q;
      done_d  = 1'b0;

      mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
      rem_sh  = acc_q[63:31];
      rem_sub = rem_sh - {1'b0, b_q};
      rem_ge  = rem_sh >= {1'b0, b_q};
      prod    = neg_q ? -acc_q : acc_q;
      // Divide by zero leaves quotient all ones regardless of sign.
      quo     = (b_q == 32'd0) ? 32'hFFFFFFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
      rem     = sa_q ? -acc_q[63:32] : acc_q[63:32];

      case (state_q)
         IDLE: if (start) begin
            case (op)
               3'd0, 3'd1: begin
                  acc_d   = {32'd0, a_mag};
                  b_d     = b_mag;
                  neg_d   = a_neg ^ b_neg;
                  sa_d    = 1'b0;
                  div_d   = 1'b0;
                  cnt_d   = 6'd0;
`ifdef MULDIV_FAST_MULT_EN
                  acc_d   = {32'd0, a_mag} * {32'd0, b_mag};
                  state_d = FIX;
`else
                  state_d = MUL;
`endif
               end
               3'd2, 3'd3: begin
                  acc_d   = {32'd0, a_mag};
                  b_d     = b_mag;
                  neg_d   = a_neg ^ b_neg;
                  sa_d    = a_neg;
                  div_d   = 1'b1;
                  cnt_d   = 6'd0;
                  state_d = DIV;
               end
               3'd4:    hi_d = a;
               3'd5:    lo_d = a;
               default: ;
            endcase
         end
         MUL: begin
            acc_d = {mul_sum, acc_q[31:1]};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = FIX;
         end
         DIV: begin
            acc_d = {(rem_ge ? rem_sub[31:0] : rem_sh[31:0]), acc_q[30:0], rem_ge};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = FIX;
         end
         FIX: begin
            if (div_q) {hi_d, lo_d} = {rem, quo};
            else       {hi_d, lo_d} = prod;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         acc_q   <= 64'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         sa_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         sa_q    <= sa_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed vectors, multi-cycle corner sequences, random ops vs. model.
module tb_mips_cpu_muldiv;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int errors = 0, checks = 0;
   logic [31:0] mhi = 32'd0, mlo = 32'd0;

`ifdef MULDIV_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   mips_cpu_muldiv dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                        .busy(busy), .done(done), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural definitions.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      longint unsigned ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (o)
         3'd0: begin q = sx * sy; return q; end
         3'd1: begin p = ux * uy; return p; end
         3'd2: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            q = sx / sy; r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         3'd3: begin
            if (y == 0) return {x, 32'hFFFFFFFF};
            p = ux / uy; ux = ux % uy;
            return {ux[31:0], p[31:0]};
         end
         default: return {mhi, mlo};
      endcase
   endfunction

   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input string nm);
      int cyc;
      bit hold_ok;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      if (o >= 3'd4) begin
         if (o == 3'd4) mhi = x;
         else if (o == 3'd5) mlo = x;
         chk({nm, " busy/done"}, {busy, done}, 2'b00);
         chk({nm, " hilo"}, {hi, lo}, {mhi, mlo});
         return;
      end
      cyc = 0; hold_ok = 1'b1;
      while (!done && cyc < 60) begin
         if (!busy || hi !== mhi || lo !== mlo) hold_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, " latency"}, cyc, (FAST && o < 3'd2) ? 1 : 33);
      chk({nm, " hold"}, hold_ok, 1);
      chk({nm, " result"}, {hi, lo}, exp);
      chk({nm, " busy at done"}, busy, 0);
      mhi = exp[63:32]; mlo = exp[31:0];
      @(posedge clk); #1;
      chk({nm, " single done"}, done, 0);
   endtask

   initial begin
      vec_t tbl[7];
      logic [2:0] ro;
      logic [31:0] ra, rb;
      int cyc, done_seen;

      tbl[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
      tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3] = '{3'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
      tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      tbl[5] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      tbl[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

      repeat (2) @(posedge clk);
      #1;
      chk("reset state", {hi, lo, busy, done}, 66'd0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++)
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, $sformatf("vec%0d", i));

      do_op(3'd4, 32'h12345678, 32'd0, 64'd0, "mthi");
      do_op(3'd5, 32'h9ABCDEF0, 32'd0, 64'd0, "mtlo");
      do_op(3'd6, 32'hDEADBEEF, 32'd1, 64'd0, "nop6");
      do_op(3'd7, 32'hCAFEF00D, 32'd2, 64'd0, "nop7");

      // Start during busy is ignored; the DIVU in flight completes normally.
      @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (!done && cyc < 60) begin
         if (cyc == 4) begin
            @(negedge clk); start = 1'b1; op = 3'd5; a = 32'd1;
         end
         @(posedge clk); #1; start = 1'b0;
         cyc++;
      end
      chk("ignore latency", cyc, 33);
      chk("ignore result", {hi, lo}, {32'd2, 32'd14});
      mhi = 32'd2; mlo = 32'd14;

      // Reset aborts an in-flight divide with no writeback or done.
      do_op(3'd4, 32'hA5A5A5A5, 32'd0, 64'd0, "mthi2");
      @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      done_seen = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 5) begin start = 1'b1; op = 3'd5; a = 32'd1; end
         if (c == 10) begin reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'h55; end
         @(posedge clk); #1; start = 1'b0;
         if (c < 10 && done) done_seen++;
      end
      reset = 1'b0;
      chk("abort reset state", {hi, lo, busy, done}, 66'd0);
      mhi = 32'd0; mlo = 32'd0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      chk("abort no done", done_seen, 0);
      chk("abort hilo held", {hi, lo}, 64'd0);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 5));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         do_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d op%0d", i, ro));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
